// File: rtl/hyper_cmd_seq.sv
// -----------------------------------------------------------------------------
// hyper_cmd_seq
//
// Queues HyperRAM transfer descriptors and issues them one at a time to the
// HyperBus peripheral over its configuration bus. For each descriptor it writes
// four registers (external address, L2 address, size, trigger). It then waits
// for the end-of-transfer event that matches the transfer direction. An
// optional watchdog abandons a transfer whose event never arrives.
//
// Ports
//   sys_clk_i        clock, rising edge
//   rstn_i           asynchronous active-low reset
//   cmd_valid_i      descriptor valid            (handshake with cmd_ready_o)
//   cmd_ready_o      descriptor FIFO has room
//   cmd_ext_addr_i   HyperRAM byte address
//   cmd_l2_addr_i    L2 start address
//   cmd_size_i       transfer size
//   cmd_rwn_i        1 = read from HyperRAM, 0 = write to HyperRAM
//   cfg_valid_o      config bus request          (handshake with cfg_ready_i)
//   cfg_addr_o       config register index
//   cfg_data_o       config write data
//   cfg_rwn_o        config direction, always 0 (write)
//   cfg_ready_i      config bus accepts request
//   evt_eot_rd_i     read transfer finished      (single-cycle pulse)
//   evt_eot_wr_i     write transfer finished     (single-cycle pulse)
//   busy_o           a descriptor is being issued or awaited
//   done_o           one-cycle pulse, transfer completed
//   timeout_o        one-cycle pulse, transfer abandoned by the watchdog
//   fifo_level_o     descriptors currently queued
//   timeout_lim_i    watchdog limit in WAIT_EOT cycles, 0 disables it
// -----------------------------------------------------------------------------
module hyper_cmd_seq #(
    parameter int DEPTH          = 4,
    parameter int L2_AWIDTH_NOAL = 19,
    parameter int TRANS_SIZE     = 20,
    parameter int TIMEOUT_W      = 16
) (
    input  logic                      sys_clk_i,
    input  logic                      rstn_i,

    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [31:0]               cmd_ext_addr_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cmd_l2_addr_i,
    input  logic [TRANS_SIZE-1:0]     cmd_size_i,
    input  logic                      cmd_rwn_i,

    output logic                      cfg_valid_o,
    output logic [4:0]                cfg_addr_o,
    output logic [31:0]               cfg_data_o,
    output logic                      cfg_rwn_o,
    input  logic                      cfg_ready_i,

    input  logic                      evt_eot_rd_i,
    input  logic                      evt_eot_wr_i,

    output logic                      busy_o,
    output logic                      done_o,
    output logic                      timeout_o,
    output logic [$clog2(DEPTH):0]    fifo_level_o,
    input  logic [TIMEOUT_W-1:0]      timeout_lim_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = 32 + L2_AWIDTH_NOAL + TRANS_SIZE + 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_EXT,
        WR_L2,
        WR_SIZE,
        WR_TRIG,
        WAIT_EOT
    } state_t;

    state_t state, state_n;

    // Descriptor FIFO
    logic [EW-1:0]  fifo_mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [LW-1:0]  level;
    logic           push;
    logic           pop;

    // Descriptor being issued
    logic [31:0]               w_ext;
    logic [L2_AWIDTH_NOAL-1:0] w_l2;
    logic [TRANS_SIZE-1:0]     w_size;
    logic                      w_rwn;

    // Watchdog and completion
    logic [TIMEOUT_W-1:0] wd_cnt;
    logic                 wd_hit;
    logic                 eot_match;
    logic                 done_set;
    logic                 done_q;

    // A full FIFO refuses a push even if the sequencer pops in the same
    // cycle; ready depends only on the registered level.
    assign cmd_ready_o  = (level != LW'(DEPTH));
    assign push         = cmd_valid_i && cmd_ready_o;
    assign pop          = (state == IDLE) && (level != '0);
    assign fifo_level_o = level;

    // ---------------- FIFO storage (data path, not reset) ----------------
    always_ff @(posedge sys_clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_ext_addr_i, cmd_l2_addr_i, cmd_size_i, cmd_rwn_i};
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (pop) begin
            {w_ext, w_l2, w_size, w_rwn} <= fifo_mem[rd_ptr];
        end
    end

    // ---------------- FIFO control ----------------
    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // ---------------- Watchdog ----------------
    // Cleared on the trigger handshake so it reads 0 in the first WAIT_EOT
    // cycle and k in the k-th cycle after entry; it saturates at all-ones.
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wd_cnt <= '0;
        end else if (state == WR_TRIG && cfg_ready_i) begin
            wd_cnt <= '0;
        end else if (state == WAIT_EOT && timeout_lim_i != '0 && wd_cnt != '1) begin
            wd_cnt <= wd_cnt + TIMEOUT_W'(1);
        end
    end

    assign wd_hit    = (timeout_lim_i != '0) && (wd_cnt == timeout_lim_i);
    assign eot_match = w_rwn ? evt_eot_rd_i : evt_eot_wr_i;

    // ---------------- FSM state register ----------------
    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= done_set;
        end
    end

    assign done_o    = done_q;
    assign cfg_rwn_o = 1'b0;

    // ---------------- FSM next state and outputs ----------------
    always_comb begin
        state_n     = state;
        cfg_valid_o = 1'b0;
        cfg_addr_o  = 5'd0;
        cfg_data_o  = 32'd0;
        busy_o      = 1'b1;
        done_set    = 1'b0;
        timeout_o   = 1'b0;

        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (level != '0) state_n = WR_EXT;
            end
            WR_EXT: begin
                cfg_valid_o = 1'b1;
                cfg_addr_o  = 5'd0;
                cfg_data_o  = w_ext;
                if (cfg_ready_i) state_n = WR_L2;
            end
            WR_L2: begin
                cfg_valid_o = 1'b1;
                cfg_addr_o  = 5'd1;
                cfg_data_o  = 32'(w_l2);
                if (cfg_ready_i) state_n = WR_SIZE;
            end
            WR_SIZE: begin
                cfg_valid_o = 1'b1;
                cfg_addr_o  = 5'd2;
                cfg_data_o  = 32'(w_size);
                if (cfg_ready_i) state_n = WR_TRIG;
            end
            WR_TRIG: begin
                cfg_valid_o = 1'b1;
                cfg_addr_o  = 5'd3;
                cfg_data_o  = {30'd0, w_rwn, 1'b1};
                if (cfg_ready_i) state_n = WAIT_EOT;
            end
            WAIT_EOT: begin
                // The matching event wins over a watchdog hit in the same
                // cycle; the opposite-direction event is ignored.
                if (eot_match) begin
                    done_set = 1'b1;
                    state_n  = IDLE;
                end else if (wd_hit) begin
                    timeout_o = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/hyper_cmd_seq.md
HYPER_CMD_SEQ -- requirements
Module: hyper_cmd_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the command FIFO depth (power of two, at least 2).
REQ-002 SHALL have parameter L2_AWIDTH_NOAL, default 19, the L2 start-address width.
REQ-003 SHALL have parameter TRANS_SIZE, default 20, the transfer-size width.
REQ-004 SHALL have parameter TIMEOUT_W, default 16, the end-of-transfer watchdog counter width.
REQ-005 SHALL have port: sys_clk_i  in  1  clock; all logic on its rising edge.
REQ-006 SHALL have port: rstn_i  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: cmd_valid_i in 1, cmd_ready_o out 1; valid/ready handshake for command descriptors.
REQ-008 SHALL have ports: cmd_ext_addr_i in 32, cmd_l2_addr_i in L2_AWIDTH_NOAL, cmd_size_i in TRANS_SIZE, cmd_rwn_i in 1 (1 = read from HyperRAM).
REQ-009 SHALL have ports: cfg_valid_o out 1, cfg_addr_o out 5, cfg_data_o out 32, cfg_rwn_o out 1, cfg_ready_i in 1; peripheral config bus master.
REQ-010 SHALL have ports: evt_eot_rd_i in 1, evt_eot_wr_i in 1; single-cycle end-of-transfer events from the hyper macro.
REQ-011 SHALL have ports: busy_o out 1, done_o out 1, timeout_o out 1, fifo_level_o out $clog2(DEPTH)+1.
REQ-012 SHALL have port: timeout_lim_i  in  TIMEOUT_W  watchdog limit; 0 disables the watchdog.

Function
REQ-013 SHALL accept a command when cmd_valid_i and cmd_ready_o are both high, storing {ext_addr, l2_addr, size, rwn} in the FIFO.
REQ-014 SHALL drive cmd_ready_o = (fifo_level_o != DEPTH); a pop in the same cycle does not free a slot for a push when the FIFO is full.
REQ-015 SHALL update fifo_level_o as +1 on push, -1 on pop, and unchanged on simultaneous push and pop; push and pop pointers wrap modulo DEPTH.
REQ-016 SHALL implement the FSM states IDLE, WR_EXT, WR_L2, WR_SIZE, WR_TRIG, WAIT_EOT.
REQ-017 SHALL, in IDLE with fifo_level_o != 0, pop the head entry into a working register and go to WR_EXT on the next cycle.
REQ-018 SHALL, in each WR_* state, hold cfg_valid_o=1 and cfg_rwn_o=0 with stable addr/data until cfg_ready_i=1, then advance on the next cycle.
REQ-019 SHALL use these config writes: WR_EXT addr 0x00 data ext_addr; WR_L2 addr 0x01 data zero-extended l2_addr; WR_SIZE addr 0x02 data zero-extended size; WR_TRIG addr 0x03 data {30'b0, rwn, 1'b1}.
REQ-020 SHALL hold cfg_valid_o=0 outside the WR_* states, and cfg_addr_o/cfg_data_o=0 in those cycles.
REQ-021 SHALL, after the WR_TRIG handshake, enter WAIT_EOT and clear the watchdog counter.
REQ-022 SHALL, in WAIT_EOT, complete on the matching event only (evt_eot_rd_i when rwn=1, evt_eot_wr_i when rwn=0), ignoring the opposite event; if both events arrive in one cycle, the matching one completes.
REQ-023 SHALL, on completion, pulse done_o for exactly one cycle (the cycle after the event) and return to IDLE.
REQ-024 SHALL, when timeout_lim_i != 0, increment the counter each WAIT_EOT cycle and, when it equals timeout_lim_i with no matching event, pulse timeout_o for one cycle and return to IDLE without done_o.
REQ-025 SHALL give a matching event priority over a timeout occurring in the same cycle.
REQ-026 SHALL drive busy_o=1 in every state except IDLE.
REQ-027 SHALL give a back-to-back latency of exactly 1 cycle from done_o to the next WR_EXT with cfg_valid_o=1, when the FIFO is non-empty.
REQ-028 SHALL keep the watchdog counter saturating and free of wrap-around.

Reset
REQ-029 SHALL, while rstn_i=0, force: state IDLE, FIFO empty, fifo_level_o=0, cmd_ready_o=1, cfg_valid_o=0, cfg_addr_o=0, cfg_data_o=0, cfg_rwn_o=0, busy_o=0, done_o=0, timeout_o=0, watchdog=0.
REQ-030 SHALL discard all queued and in-flight commands on reset mid-operation, without completing any pending handshake.

Verification
REQ-031 SHALL be verified by: push {0x1000, 0x200, 64, rd} with cfg_ready_i=1 -> writes 0x00=0x1000, 0x01=0x200, 0x02=64, 0x03=0x3 on consecutive handshakes; evt_eot_rd_i -> done_o pulses once, busy_o=0.
REQ-032 SHALL be verified by: write command with evt_eot_rd_i pulsed in WAIT_EOT -> ignored; a later evt_eot_wr_i -> done_o.
REQ-033 SHALL be verified by: 5 pushes with DEPTH=4 while stalled -> 5th blocked (cmd_ready_o=0, level=4); after the first pop, level=3 and the push is accepted.
REQ-034 SHALL be verified by: cfg_ready_i held low for 7 cycles in WR_SIZE -> cfg_valid_o, addr and data stable for all 8 cycles.
REQ-035 SHALL be verified by: timeout_lim_i=10 with no event -> timeout_o pulses 10 cycles after WAIT_EOT entry with no done_o, then the next command starts; event and timeout in the same cycle -> done_o only.
REQ-036 SHALL be verified by: rstn_i asserted during WR_L2 with 2 queued commands -> all outputs return to reset values and fifo_level_o=0.
